// File: rtl/icu.sv
// ---------------------------------------------------------------------------
// icu -- interrupt control unit
//
// Purpose
//   Detects a rising edge on the level interrupt request and runs a short
//   sequence that takes over the shared datapath control signals. The
//   sequence pushes the return address (high half first, then low half) and,
//   optionally, the condition flags onto the stack. It then reads the
//   handler address from data memory at VECTOR_ADDR and jumps to it with a
//   one-cycle pc_load strobe. A request that arrives while a sequence is
//   running is remembered in a one-deep pending flag.
//
// Configuration
//   ICU_FLAGS_SAVE_EN  defined   : the PUSH_FLAGS state is present. The unit
//                                  makes 3 pushes and holds int_flag high for
//                                  5 cycles.
//                      undefined : PUSH_PC_LO goes straight to FETCH_VEC. The
//                                  unit makes 2 pushes, holds int_flag high
//                                  for 4 cycles, and ignores flags.
//
// Parameters
//   VECTOR_ADDR      data-memory word address that holds the handler address
//
// Ports
//   clk              sole clock; all state changes on the rising edge
//   rst              synchronous reset, active low; has priority over hold
//   int_req          external interrupt request (level, synchronous)
//   hold             pipeline stall; freezes the sequence and the outputs
//   pc[31:0]         address of the next instruction (the return address)
//   flags[2:0]       condition code register {C,N,Z}
//   mem_rdata[15:0]  data-memory read data
//   int_flag         high while a sequence is in progress
//   alu_function     4'b0100 while pushing, 4'b0000 in other active states
//   branch, data_read, data_write
//                    0 while active
//   DMW, stack_operation, push_pop, write_sp
//                    1 in push states, 0 in other active states
//   push_data[15:0]  word being pushed; 0 outside push states
//   vec_read         read of VECTOR_ADDR requested
//   mem_addr[31:0]   VECTOR_ADDR while vec_read=1, else 0
//   pc_out[31:0]     handler address, zero-extended
//   pc_load          one-cycle strobe that loads pc_out into the PC
//
// The shared control signals (alu_function, branch, data_read, data_write,
// DMW, stack_operation, push_pop, write_sp) go to high impedance while the
// unit is idle. This lets the control unit drive the same nets.
// ---------------------------------------------------------------------------
module icu #(
    parameter logic [31:0] VECTOR_ADDR = 32'h0000_0006
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        int_req,
    input  logic        hold,
    input  logic [31:0] pc,
    input  logic [2:0]  flags,
    input  logic [15:0] mem_rdata,
    output logic        int_flag,
    output logic [3:0]  alu_function,
    output logic        branch,
    output logic        data_read,
    output logic        data_write,
    output logic        DMW,
    output logic        stack_operation,
    output logic        push_pop,
    output logic        write_sp,
    output logic [15:0] push_data,
    output logic        vec_read,
    output logic [31:0] mem_addr,
    output logic [31:0] pc_out,
    output logic        pc_load
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_PUSH_PC_HI = 3'd1,
        S_PUSH_PC_LO = 3'd2,
        S_PUSH_FLAGS = 3'd3,
        S_FETCH_VEC  = 3'd4,
        S_JUMP       = 3'd5
    } state_t;

    // -----------------------------------------------------------------------
    // State and captured context
    // -----------------------------------------------------------------------
    state_t      r_state;
    logic        r_int_prev;     // int_req as sampled at the previous edge
    logic        r_pending;      // one-deep queue for requests seen while busy
    logic [31:0] r_ret;          // return address captured at sequence start
    logic [15:0] r_vector;       // handler address read from VECTOR_ADDR

    // Registered outputs, all updated together with r_state
    logic        r_int_flag;
    logic        r_push;         // currently in a push state
    logic [15:0] r_push_data;
    logic        r_vec_read;
    logic        r_pc_load;

    // Next-state helpers
    logic        w_req;
    logic        w_start;
    state_t      w_state_next;
    logic [31:0] w_ret_next;
    logic [15:0] w_push_data_next;
    logic        w_push_next;

`ifdef ICU_FLAGS_SAVE_EN
    logic [2:0]  r_flags;        // flags captured at sequence start
    logic [2:0]  w_flags_next;
`else
    // flags has no use when flag saving is disabled.
    logic        w_unused_flags;
    assign w_unused_flags = ^flags;
`endif

    // -----------------------------------------------------------------------
    // Request detection and next-state decode
    // -----------------------------------------------------------------------
    always_comb begin
        // A request is a rising edge seen over two consecutive clock edges.
        // r_int_prev is cleared in reset. So if int_req is held high through
        // reset release, it still counts as exactly one request.
        w_req   = int_req & ~r_int_prev;
        w_start = (r_state == S_IDLE) & (w_req | r_pending);

        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_start) begin
                    w_state_next = S_PUSH_PC_HI;
                end
            end
            S_PUSH_PC_HI: w_state_next = S_PUSH_PC_LO;
            S_PUSH_PC_LO: begin
`ifdef ICU_FLAGS_SAVE_EN
                w_state_next = S_PUSH_FLAGS;
`else
                w_state_next = S_FETCH_VEC;
`endif
            end
            S_PUSH_FLAGS: w_state_next = S_FETCH_VEC;
            S_FETCH_VEC:  w_state_next = S_JUMP;
            S_JUMP:       w_state_next = S_IDLE;
            default:      w_state_next = S_IDLE;
        endcase

        // The context is sampled on the same edge that leaves IDLE. So the
        // first push uses pc directly; later states use the captured copy.
        w_ret_next = w_start ? pc : r_ret;
`ifdef ICU_FLAGS_SAVE_EN
        w_flags_next = w_start ? flags : r_flags;
`endif

        w_push_data_next = 16'h0000;
        w_push_next      = 1'b0;
        case (w_state_next)
            S_PUSH_PC_HI: begin
                w_push_data_next = w_ret_next[31:16];
                w_push_next      = 1'b1;
            end
            S_PUSH_PC_LO: begin
                w_push_data_next = w_ret_next[15:0];
                w_push_next      = 1'b1;
            end
`ifdef ICU_FLAGS_SAVE_EN
            S_PUSH_FLAGS: begin
                w_push_data_next = {13'b0, w_flags_next};
                w_push_next      = 1'b1;
            end
`endif
            default: begin
                w_push_data_next = 16'h0000;
                w_push_next      = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Sequencer: state, captured context and registered outputs
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_int_prev  <= 1'b0;
            r_pending   <= 1'b0;
            r_ret       <= 32'h0000_0000;
            r_vector    <= 16'h0000;
            r_int_flag  <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= 16'h0000;
            r_vec_read  <= 1'b0;
            r_pc_load   <= 1'b0;
`ifdef ICU_FLAGS_SAVE_EN
            r_flags     <= 3'b000;
`endif
        end else begin
            // Edge detection keeps running during hold, so an edge that
            // arrives during a stall is not lost. It is queued instead.
            r_int_prev <= int_req;

            // Starting a sequence uses up the pending request. Any other
            // request fills the queue. If the queue is already full, the
            // request is dropped.
            if (!hold && w_start) begin
                r_pending <= 1'b0;
            end else if (w_req) begin
                r_pending <= 1'b1;
            end

            if (!hold) begin
                r_state <= w_state_next;
                r_ret   <= w_ret_next;
`ifdef ICU_FLAGS_SAVE_EN
                r_flags <= w_flags_next;
`endif
                // The handler address is taken at the end of the read cycle.
                if (r_state == S_FETCH_VEC) begin
                    r_vector <= mem_rdata;
                end

                r_int_flag  <= (w_state_next != S_IDLE);
                r_push      <= w_push_next;
                r_push_data <= w_push_data_next;
                r_vec_read  <= (w_state_next == S_FETCH_VEC);
                r_pc_load   <= (w_state_next == S_JUMP);
            end
        end
    end

    // -----------------------------------------------------------------------
    // Output drive
    // -----------------------------------------------------------------------
    assign int_flag  = r_int_flag;
    assign push_data = r_push_data;
    assign vec_read  = r_vec_read;
    assign mem_addr  = r_vec_read ? VECTOR_ADDR : 32'h0000_0000;
    assign pc_out    = {16'h0000, r_vector};
    assign pc_load   = r_pc_load;

    // Shared control nets: driven only while a sequence owns the datapath.
    assign alu_function    = r_int_flag ? (r_push ? 4'b0100 : 4'b0000) : 4'bzzzz;
    assign branch          = r_int_flag ? 1'b0   : 1'bz;
    assign data_read       = r_int_flag ? 1'b0   : 1'bz;
    assign data_write      = r_int_flag ? 1'b0   : 1'bz;
    assign DMW             = r_int_flag ? r_push : 1'bz;
    assign stack_operation = r_int_flag ? r_push : 1'bz;
    assign push_pop        = r_int_flag ? r_push : 1'bz;
    assign write_sp        = r_int_flag ? r_push : 1'bz;

endmodule

// File: doc/icu.md
ICU -- requirements
Module: icu

Interface
REQ-001 Parameter VECTOR_ADDR, default 32'h0000_0006, data-memory word address holding the interrupt handler address.
REQ-002 clk  in  1  sole clock; all state updates on rising edge.
REQ-003 rst  in  1  reset, synchronous and active-low.
REQ-004 int_req  in  1  external interrupt request, level, synchronous to clk.
REQ-005 hold  in  1  pipeline stall; freezes the FSM.
REQ-006 pc  in  32  PC of next instruction to execute, i.e. the return address.
REQ-007 flags  in  3  CCR {C,N,Z}.
REQ-008 mem_rdata  in  16  data-memory read data.
REQ-009 int_flag  out  1  ICU owns shared control signals; CU releases them to z.
REQ-010 alu_function  out  4  4'b0100 (pass operand 2) while pushing, else 4'b0000; z when idle.
REQ-011 branch, data_read, data_write  out  1 each  0 while active; z when idle.
REQ-012 DMW, stack_operation, push_pop, write_sp  out  1 each  1 in push states, 0 in other active states; z when idle.
REQ-013 push_data  out  16  word to push.
REQ-014 vec_read  out  1  memory read of VECTOR_ADDR requested.
REQ-015 mem_addr  out  32  VECTOR_ADDR when vec_read=1, else 0.
REQ-016 pc_out  out  32  handler address.
REQ-017 pc_load  out  1  one-cycle strobe loading pc_out into PC.

Function
REQ-018 States: IDLE, PUSH_PC_HI, PUSH_PC_LO, PUSH_FLAGS, FETCH_VEC, JUMP; one cycle per state unless hold=1.
REQ-019 Request = int_req rising edge (int_req=1, registered previous=0); in IDLE, request or pending=1 moves to PUSH_PC_HI next cycle and clears pending.
REQ-020 Return address is captured into an internal register on the IDLE->PUSH_PC_HI transition; later pc changes are ignored.
REQ-021 PUSH_PC_HI pushes ret[31:16]; PUSH_PC_LO pushes ret[15:0]; PUSH_FLAGS pushes {13'b0,flags sampled at capture}.
REQ-022 FETCH_VEC: vec_read=1, mem_addr=VECTOR_ADDR; mem_rdata is registered at end of that cycle.
REQ-023 JUMP: pc_out={16'b0,captured vector}, pc_load=1 for exactly one cycle; next state IDLE.
REQ-024 int_flag=1 in every state except IDLE, and 0 in IDLE.
REQ-025 hold=1: state, captured registers and all outputs hold; pc_load repeats no strobe until hold drops.
REQ-026 Request while not IDLE sets pending; if pending already 1, the request is dropped (one-deep).
REQ-027 Request in the JUMP cycle sets pending; ICU re-enters PUSH_PC_HI after exactly one IDLE cycle.
REQ-028 push_data=0, vec_read=0, pc_load=0 outside their states.

Reset
REQ-029 rst=0 at any clock edge, including mid-sequence: state=IDLE, pending=0, previous int_req=0, captured registers=0, int_flag=0, pc_load=0, vec_read=0; rst has priority over hold.
REQ-030 int_req held high across reset release is counted as one request.

Configuration
REQ-031 ICU_FLAGS_SAVE_EN defined: PUSH_FLAGS state present, 3 pushes, int_flag high 5 cycles; undefined: PUSH_PC_LO goes directly to FETCH_VEC, 2 pushes, int_flag high 4 cycles, flags unused.

Verification
REQ-032 pc=32'h0001_0042, flags=3'b101, mem_rdata=16'h0300, pulse int_req -> pushes 16'h0001, 16'h0042, 16'h0005; pc_load with pc_out=32'h0000_0300 four cycles after first push.
REQ-033 Same with ICU_FLAGS_SAVE_EN undefined -> pushes 16'h0001, 16'h0042 only; pc_load three cycles after first push.
REQ-034 hold=1 for 3 cycles during PUSH_PC_LO -> push_data stays 16'h0042 and DMW stays 1 for 4 cycles; sequence completes unchanged.
REQ-035 Second int_req edge in PUSH_PC_HI, third in FETCH_VEC -> exactly two complete sequences, separated by one IDLE cycle.
REQ-036 rst=0 during FETCH_VEC -> next cycle IDLE, int_flag=0, no pc_load; int_req held high at release -> one new sequence.
